// File: rtl/eei_batch_issuer_pkg.sv
// Shared constants and types for the EEI batch issuer: lane limits, the SAVE/RESTORE
// funct7 encodings and the issuer state type.
package eei_batch_issuer_pkg;

   localparam int EEI_RS_MAX = 4;
   localparam int EEI_RD_MAX = 4;

   localparam logic [6:0] EEI_F7_SAVE    = 7'b0000000;
   localparam logic [6:0] EEI_F7_RESTORE = 7'b1000000;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ISSUE,
      WB,
      DONE
   } eei_iss_state_e;

endpackage

// File: rtl/eei_batch_issuer_calc.sv
// Combinational batch splitter: picks the next batch length, its lane mask and the
// start/remaining values the command advances to once that batch completes.
module eei_batch_calc #(
   parameter int LANES = 4
) (
   input  logic [5:0]       start_i,
   input  logic [5:0]       rem_i,
   input  logic [5:0]       max_i,
   output logic [4:0]       len_o,
   output logic [LANES-1:0] mask_o,
   output logic [5:0]       next_start_o,
   output logic [5:0]       next_rem_o
);

   always_comb begin
      // max_i never exceeds 31, so a 5-bit length always holds the minimum
      len_o = (rem_i < max_i) ? rem_i[4:0] : max_i[4:0];
      for (int k = 0; k < LANES; k++) begin
         mask_o[k] = (k < int'(len_o));
      end
      next_start_o = start_i + {1'b0, len_o};
      next_rem_o   = rem_i - {1'b0, len_o};
   end

endmodule

// File: rtl/eei_batch_issuer.sv
// Core-side EEI batch initiator: splits one SAVE/RESTORE/pass-through command into
// register batches, handshakes each with req/ack and writes restored values to the GPRs.
module eei_batch_issuer
   import eei_batch_issuer_pkg::*;
#(
   parameter int RS_MAX      = EEI_RS_MAX,
   parameter int RD_MAX      = EEI_RD_MAX,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [6:0]           cmd_funct7_i,
   input  logic [4:0]           cmd_start_i,
   input  logic [5:0]           cmd_len_i,
   output logic [4:0]           gpr_rd_base_o,
   input  logic [32*RS_MAX-1:0] gpr_rd_val_i,
   output logic [RD_MAX-1:0]    gpr_wr_en_o,
   output logic [4:0]           gpr_wr_base_o,
   output logic [32*RD_MAX-1:0] gpr_wr_val_o,
   output logic                 eei_req_o,
   output logic [6:0]           eei_funct7_o,
   output logic [4:0]           eei_batch_start_o,
   output logic [4:0]           eei_batch_len_o,
   output logic [32*RS_MAX-1:0] eei_rs_val_o,
   input  logic                 eei_ack_i,
   input  logic                 eei_error_i,
   input  logic [32*RD_MAX-1:0] eei_rd_val_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [5:0] RS_MAX6 = 6'(RS_MAX);
   localparam logic [5:0] RD_MAX6 = 6'(RD_MAX);

   // Saturate the requested count so the command never runs past x31.
   function automatic logic [5:0] clip_len(input logic [5:0] len, input logic [4:0] start);
      logic [5:0] avail;
      avail = 6'd32 - {1'b0, start};
      return (len > avail) ? avail : len;
   endfunction

   eei_iss_state_e state_q, state_d;

   logic [6:0]           f7_q, f7_d;
   logic [5:0]           start_q, start_d;
   logic [5:0]           rem_q, rem_d;
   logic                 err_q, err_d;
   logic [4:0]           bstart_q;
   logic [4:0]           blen_q;
   logic [32*RS_MAX-1:0] rs_val_q;
   logic [32*RD_MAX-1:0] rd_val_q;
   logic [TW-1:0]        tmo_q;

   logic                 is_restore;
   logic [5:0]           max_sel;
   logic [5:0]           len_clip;
   logic [4:0]           c_len;
   logic [RS_MAX-1:0]    c_mask;
   logic [5:0]           c_nstart;
   logic [5:0]           c_nrem;
   logic [32*RS_MAX-1:0] rs_masked;
   logic                 ld_batch;
   logic                 cap_rd;
   logic                 tmo_clr;
   logic                 tmo_inc;
   logic                 tmo_hit;

   assign is_restore = (f7_q == EEI_F7_RESTORE);
   assign max_sel    = is_restore ? RD_MAX6 : RS_MAX6;
   assign len_clip   = clip_len(cmd_len_i, cmd_start_i);
   assign tmo_hit    = (TIMEOUT_CYC != 0) && (tmo_q == TW'(TIMEOUT_CYC - 1));

   eei_batch_calc #(
      .LANES(RS_MAX)
   ) u_calc (
      .start_i     (start_q),
      .rem_i       (rem_q),
      .max_i       (max_sel),
      .len_o       (c_len),
      .mask_o      (c_mask),
      .next_start_o(c_nstart),
      .next_rem_o  (c_nrem)
   );

   // Lanes beyond the batch length are zeroed; the clip keeps base+k<=31 for live lanes.
   always_comb begin
      rs_masked = '0;
      for (int k = 0; k < RS_MAX; k++) begin
         if (c_mask[k]) begin
            rs_masked[k*32 +: 32] = gpr_rd_val_i[k*32 +: 32];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      f7_d     = f7_q;
      start_d  = start_q;
      rem_d    = rem_q;
      err_d    = err_q;
      ld_batch = 1'b0;
      cap_rd   = 1'b0;
      tmo_clr  = 1'b0;
      tmo_inc  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               f7_d    = cmd_funct7_i;
               start_d = {1'b0, cmd_start_i};
               rem_d   = len_clip;
               err_d   = 1'b0;
               state_d = (len_clip == 6'd0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            ld_batch = 1'b1;
            tmo_clr  = 1'b1;
            state_d  = ISSUE;
         end
         ISSUE: begin
            if (eei_ack_i) begin
               if (eei_error_i) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (is_restore) begin
                  cap_rd  = 1'b1;
                  state_d = WB;
               end else begin
                  start_d = c_nstart;
                  rem_d   = c_nrem;
                  state_d = (c_nrem == 6'd0) ? DONE : LOAD;
               end
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         WB: begin
            start_d = c_nstart;
            rem_d   = c_nrem;
            state_d = (c_nrem == 6'd0) ? DONE : LOAD;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         f7_q    <= '0;
         start_q <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         f7_q    <= f7_d;
         start_q <= start_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
         if (tmo_clr) begin
            tmo_q <= '0;
         end else if (tmo_inc) begin
            tmo_q <= tmo_q + 1'b1;
         end
      end
   end

   // Batch payload stage: captured in LOAD, held steady through ISSUE until ack.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bstart_q <= '0;
         blen_q   <= '0;
         rs_val_q <= '0;
         rd_val_q <= '0;
      end else begin
         if (ld_batch) begin
            bstart_q <= start_q[4:0];
            blen_q   <= c_len;
            rs_val_q <= is_restore ? '0 : rs_masked;
         end
         if (cap_rd) begin
            rd_val_q <= eei_rd_val_i;
         end
      end
   end

   // Writeback stage: one-cycle lane enables for the restored batch.
   always_comb begin
      gpr_wr_en_o = '0;
      for (int k = 0; k < RD_MAX; k++) begin
         gpr_wr_en_o[k] = (state_q == WB) && (k < int'(blen_q));
      end
   end

   assign cmd_ready_o       = (state_q == IDLE);
   assign busy_o            = (state_q != IDLE);
   assign done_o            = (state_q == DONE);
   assign err_o             = (state_q == DONE) && err_q;
   assign eei_req_o         = (state_q == ISSUE);
   assign gpr_rd_base_o     = start_q[4:0];
   assign eei_funct7_o      = f7_q;
   assign eei_batch_start_o = bstart_q;
   assign eei_batch_len_o   = blen_q;
   assign eei_rs_val_o      = rs_val_q;
   assign gpr_wr_base_o     = bstart_q;
   assign gpr_wr_val_o      = rd_val_q;

endmodule

// File: tb/tb_eei_batch_issuer.sv
// Self-checking bench for eei_batch_issuer: acts as GPR file and EEI responder and
// compares every batch, writeback and completion against a register-level model.
module tb_eei_batch_issuer;
   import eei_batch_issuer_pkg::*;

   localparam int RS  = 4;
   localparam int RD  = 4;
   localparam int TMO = 8;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             cmd_valid_i;
   logic             cmd_ready_o;
   logic [6:0]       cmd_funct7_i;
   logic [4:0]       cmd_start_i;
   logic [5:0]       cmd_len_i;
   logic [4:0]       gpr_rd_base_o;
   logic [32*RS-1:0] gpr_rd_val_i;
   logic [RD-1:0]    gpr_wr_en_o;
   logic [4:0]       gpr_wr_base_o;
   logic [32*RD-1:0] gpr_wr_val_o;
   logic             eei_req_o;
   logic [6:0]       eei_funct7_o;
   logic [4:0]       eei_batch_start_o;
   logic [4:0]       eei_batch_len_o;
   logic [32*RS-1:0] eei_rs_val_o;
   logic             eei_ack_i;
   logic             eei_error_i;
   logic [32*RD-1:0] eei_rd_val_i;
   logic             busy_o;
   logic             done_o;
   logic             err_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] gpr_tb  [32];
   logic [31:0] gpr_ref [32];

   eei_batch_issuer #(
      .RS_MAX     (RS),
      .RD_MAX     (RD),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .cmd_valid_i      (cmd_valid_i),
      .cmd_ready_o      (cmd_ready_o),
      .cmd_funct7_i     (cmd_funct7_i),
      .cmd_start_i      (cmd_start_i),
      .cmd_len_i        (cmd_len_i),
      .gpr_rd_base_o    (gpr_rd_base_o),
      .gpr_rd_val_i     (gpr_rd_val_i),
      .gpr_wr_en_o      (gpr_wr_en_o),
      .gpr_wr_base_o    (gpr_wr_base_o),
      .gpr_wr_val_o     (gpr_wr_val_o),
      .eei_req_o        (eei_req_o),
      .eei_funct7_o     (eei_funct7_o),
      .eei_batch_start_o(eei_batch_start_o),
      .eei_batch_len_o  (eei_batch_len_o),
      .eei_rs_val_o     (eei_rs_val_o),
      .eei_ack_i        (eei_ack_i),
      .eei_error_i      (eei_error_i),
      .eei_rd_val_i     (eei_rd_val_i),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .err_o            (err_o)
   );

   always #5 clk_i = ~clk_i;

   // GPR read port wraps past x31 on purpose so unmasked lanes would show real data.
   always_comb begin
      for (int k = 0; k < RS; k++) begin
         gpr_rd_val_i[k*32 +: 32] = gpr_tb[(int'(gpr_rd_base_o) + k) % 32];
      end
   end

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One command end to end; err_b = batch acked with error, noack_b = batch never acked.
   task automatic run_cmd(input logic [6:0] f7, input int start, input int len,
                          input int err_b, input int noack_b, input int fix_delay);
      bit           is_rs, done_seen, in_req, wb_pend, exp_err;
      int           mx, clip, nb, last, b, n_req, cyc, exp_cyc, d, ack_wait;
      int           req_cycles, wb_cnt, exp_wb, s, l, wb_base, wb_len, nmis;
      logic [127:0] exp_rs, hold_rs;
      logic [16:0]  hold_hdr;
      logic [32*RD-1:0] rdv;
      logic [RD-1:0] exp_en;

      is_rs   = (f7 == EEI_F7_RESTORE);
      mx      = is_rs ? RD : RS;
      clip    = (len < 32 - start) ? len : 32 - start;
      nb      = (clip + mx - 1) / mx;
      last    = nb;
      exp_err = 1'b0;
      if (err_b >= 0 && err_b < nb) begin
         last = err_b + 1; exp_err = 1'b1;
      end
      if (noack_b >= 0 && noack_b < nb) begin
         last = noack_b + 1; exp_err = 1'b1;
      end
      exp_wb = is_rs ? (exp_err ? last - 1 : nb) : 0;
      b = 0; n_req = 0; cyc = 0; exp_cyc = 1; d = 0; ack_wait = 0;
      req_cycles = 0; wb_cnt = 0; wb_base = 0; wb_len = 0;
      done_seen = 1'b0; in_req = 1'b0; wb_pend = 1'b0;
      hold_rs = '0; hold_hdr = '0; exp_en = '0; rdv = '0;

      @(negedge clk_i);
      check("cmd_ready", cmd_ready_o, 1);
      cmd_valid_i  = 1'b1;
      cmd_funct7_i = f7;
      cmd_start_i  = 5'(start);
      cmd_len_i    = 6'(len);
      @(posedge clk_i);
      #1 cmd_valid_i = 1'b0;

      while (!done_seen && cyc < 300) begin
         @(negedge clk_i);
         cyc++;
         eei_ack_i   = 1'b0;
         eei_error_i = 1'b0;
         if (wb_pend) begin
            check("wb_en", gpr_wr_en_o, exp_en);
            check("wb_base", gpr_wr_base_o, wb_base);
            for (int k = 0; k < wb_len; k++)
               check("wb_val", gpr_wr_val_o[k*32 +: 32], rdv[k*32 +: 32]);
            for (int k = 0; k < RD; k++)
               if (gpr_wr_en_o[k]) gpr_tb[(int'(gpr_wr_base_o) + k) % 32] = gpr_wr_val_o[k*32 +: 32];
            wb_pend = 1'b0;
            wb_cnt++;
         end else begin
            check("wr_en_quiet", gpr_wr_en_o, 0);
         end
         if (done_o) begin
            done_seen = 1'b1;
            check("done_cycle", cyc, exp_cyc);
            check("done_err", err_o, exp_err);
            check("req_at_done", eei_req_o, 0);
            if (noack_b >= 0 && noack_b < nb) check("timeout_req_cycles", req_cycles, TMO);
         end else if (eei_req_o) begin
            if (!in_req) begin
               in_req = 1'b1;
               req_cycles = 0;
               n_req++;
               s = start + b * mx;
               l = (clip - b * mx < mx) ? clip - b * mx : mx;
               check("batch_in_range", (b < last), 1);
               check("batch_start", eei_batch_start_o, s);
               check("batch_len", eei_batch_len_o, l);
               check("batch_f7", eei_funct7_o, f7);
               exp_rs = '0;
               for (int k = 0; k < RS; k++)
                  if (k < l) exp_rs[k*32 +: 32] = gpr_ref[(s + k) % 32];
               if (!is_rs) check("rs_val", eei_rs_val_o, exp_rs);
               hold_rs  = eei_rs_val_o;
               hold_hdr = {eei_batch_start_o, eei_batch_len_o, eei_funct7_o};
               if (b == noack_b) d = 100000;
               else if (fix_delay >= 0) d = fix_delay;
               else d = $urandom_range(0, 4);
               exp_cyc += 1 + ((b == noack_b) ? TMO : d + 1) +
                          ((is_rs && b != err_b && b != noack_b) ? 1 : 0);
               ack_wait = d;
            end else begin
               check("hold_hdr", {eei_batch_start_o, eei_batch_len_o, eei_funct7_o}, hold_hdr);
               check("hold_rs", eei_rs_val_o, hold_rs);
            end
            req_cycles++;
            if (ack_wait == 0) begin
               check("req_hold_cycles", req_cycles, d + 1);
               eei_ack_i   = 1'b1;
               eei_error_i = (b == err_b);
               for (int k = 0; k < RD; k++) rdv[k*32 +: 32] = $urandom;
               eei_rd_val_i = rdv;
               if (is_rs && b != err_b) begin
                  wb_pend = 1'b1;
                  wb_base = s;
                  wb_len  = l;
                  exp_en  = '0;
                  for (int k = 0; k < l; k++) begin
                     exp_en[k] = 1'b1;
                     gpr_ref[s + k] = rdv[k*32 +: 32];
                  end
               end
               b++;
               in_req = 1'b0;
            end else begin
               ack_wait--;
            end
         end
      end
      check("done_seen", done_seen, 1);
      check("req_count", n_req, last);
      check("wb_count", wb_cnt, exp_wb);
      nmis = 0;
      for (int r = 0; r < 32; r++) if (gpr_tb[r] !== gpr_ref[r]) nmis++;
      check("gpr_file", nmis, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [6:0] rf7;
      int         rsel, rstart, rlen, rerr;
      bit         saw_req;

      for (int r = 0; r < 32; r++) begin
         gpr_tb[r]  = $urandom;
         gpr_ref[r] = gpr_tb[r];
      end
      rst_ni       = 1'b0;
      cmd_valid_i  = 1'b0;
      cmd_funct7_i = '0;
      cmd_start_i  = '0;
      cmd_len_i    = '0;
      eei_ack_i    = 1'b0;
      eei_error_i  = 1'b0;
      eei_rd_val_i = '0;
      repeat (3) @(negedge clk_i);
      check("rst_ready", cmd_ready_o, 1);
      check("rst_req", eei_req_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_wr_en", gpr_wr_en_o, 0);
      check("rst_rs_val", eei_rs_val_o, 0);
      check("rst_hdr", {eei_batch_start_o, eei_batch_len_o, eei_funct7_o, gpr_rd_base_o}, 0);
      rst_ni = 1'b1;

      run_cmd(EEI_F7_SAVE, 1, 10, -1, -1, 0);
      run_cmd(EEI_F7_RESTORE, 28, 8, -1, -1, -1);
      run_cmd(EEI_F7_SAVE, 7, 0, -1, -1, -1);
      run_cmd(EEI_F7_RESTORE, 0, 12, 1, -1, -1);
      run_cmd(EEI_F7_SAVE, 3, 6, -1, -1, 5);
      run_cmd(EEI_F7_SAVE, 0, 4, -1, 0, -1);
      run_cmd(7'h25, 30, 5, -1, -1, -1);
      run_cmd(EEI_F7_RESTORE, 0, 32, -1, -1, -1);

      // Reset while a request is outstanding.
      @(negedge clk_i);
      cmd_valid_i  = 1'b1;
      cmd_funct7_i = EEI_F7_SAVE;
      cmd_start_i  = 5'd5;
      cmd_len_i    = 6'd8;
      @(posedge clk_i);
      #1 cmd_valid_i = 1'b0;
      saw_req = 1'b0;
      for (int i = 0; i < 10 && !saw_req; i++) begin
         @(negedge clk_i);
         saw_req = eei_req_o;
      end
      check("rst_mid_req_seen", saw_req, 1);
      #2 rst_ni = 1'b0;
      #1;
      check("rst_mid_req_drop", eei_req_o, 0);
      check("rst_mid_ready", cmd_ready_o, 1);
      check("rst_mid_done", done_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("post_rst_done", done_o, 0);
      check("post_rst_ready", cmd_ready_o, 1);
      run_cmd(EEI_F7_SAVE, 5, 8, -1, -1, -1);

      for (int t = 0; t < 40; t++) begin
         rsel = $urandom_range(0, 2);
         if (rsel == 0) rf7 = EEI_F7_SAVE;
         else if (rsel == 1) rf7 = EEI_F7_RESTORE;
         else rf7 = 7'($urandom_range(1, 63));
         rstart = $urandom_range(0, 31);
         rlen   = $urandom_range(0, 32);
         rerr   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
         run_cmd(rf7, rstart, rlen, rerr, -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
